// File: rtl/div_fibonacci_arb.sv
// div_fibonacci_arb: round-robin sequencer that shares one div_fibonacci
// divider between N_REQ requesters. The winner's operands are latched. The
// divider gets a one-cycle start pulse, and its done pulse is turned into a
// one-cycle response to the winner. A zero divisor is answered directly with
// an error and never reaches the divider. A divider that never finishes is
// cut off after TIMEOUT cycles and locks the arbiter until reset.
// Assumes N_REQ in 2..8, TIMEOUT >= 1 and GAP >= 1.
module div_fibonacci_arb #(
  parameter int N_REQ   = 4,
  parameter int DW      = 32,
  parameter int TIMEOUT = 1023,
  parameter int GAP     = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*DW-1:0] req_i,
  input  logic [N_REQ*DW-1:0] req_j,
  output logic [N_REQ-1:0]    grant,
  output logic [N_REQ-1:0]    resp_valid,
  output logic [DW-1:0]       resp_q,
  output logic [DW-1:0]       resp_r,
  output logic                resp_err,
  output logic                locked,
  output logic                div_en,
  output logic [DW-1:0]       div_i,
  output logic [DW-1:0]       div_j,
  input  logic [DW-1:0]       div_q,
  input  logic [DW-1:0]       div_r,
  input  logic                div_done
);

  localparam int PW = $clog2(N_REQ);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int GW = $clog2(GAP + 2);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, GAP_S, LOCK} state_e;

  state_e              state_q;
  logic [PW-1:0]       rr_ptr_q;
  logic [PW-1:0]       owner_q;
  logic [TW-1:0]       timer_q;
  logic [GW-1:0]       gap_q;
  logic [N_REQ-1:0]    grant_q;
  logic [N_REQ-1:0]    resp_valid_q;
  logic [DW-1:0]       resp_q_q;
  logic [DW-1:0]       resp_r_q;
  logic                resp_err_q;
  logic                locked_q;
  logic                div_en_q;
  logic [DW-1:0]       div_i_q;
  logic [DW-1:0]       div_j_q;

  logic [PW-1:0]       owner_d;
  logic                owner_vld_d;
  logic [CW-1:0]       cand;
  logic                enter_resp;
  logic                hit_timeout;
  logic [DW-1:0]       resp_q_d;
  logic [DW-1:0]       resp_r_d;
  logic                resp_err_d;

  // Pick the first pending request at or after rr_ptr, wrapping explicitly
  // because N_REQ need not be a power of two.
  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path can
    // leave it holding an old value and infer a latch.
    owner_vld_d = 1'b0;
    owner_d     = '0;
    cand        = '0;
    // Walk offsets from the far end so the nearest candidate is written last.
    for (int o = N_REQ - 1; o >= 0; o--) begin
      cand = {1'b0, rr_ptr_q} + CW'(o);
      if (cand >= CW'(N_REQ)) cand = cand - CW'(N_REQ);
      if (req[cand[PW-1:0]]) begin
        owner_vld_d = 1'b1;
        owner_d     = cand[PW-1:0];
      end
    end
  end

  // Decide whether this cycle hands a result to RESP, and which result.
  // The zero-divisor test looks at the latched divisor, so it is made in
  // ISSUE, which then skips the start pulse entirely.
  always_comb begin
    enter_resp  = 1'b0;
    hit_timeout = 1'b0;
    resp_q_d    = '0;
    resp_r_d    = '0;
    resp_err_d  = 1'b0;
    case (state_q)
      ISSUE: begin
        if (div_j_q == '0) begin
          enter_resp = 1'b1;
          resp_err_d = 1'b1;
        end
      end
      WAIT: begin
        if (div_done) begin
          enter_resp = 1'b1;
          resp_q_d   = div_q;
          resp_r_d   = div_r;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          enter_resp  = 1'b1;
          hit_timeout = 1'b1;
          resp_err_d  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      owner_q      <= '0;
      timer_q      <= '0;
      gap_q        <= '0;
      grant_q      <= '0;
      resp_valid_q <= '0;
      resp_q_q     <= '0;
      resp_r_q     <= '0;
      resp_err_q   <= 1'b0;
      locked_q     <= 1'b0;
      div_en_q     <= 1'b0;
      div_i_q      <= '0;
      div_j_q      <= '0;
    end else begin
      // NOTE: state is updated with non-blocking assignments, so every
      // right-hand side in this block reads the value from before the edge.
      div_en_q     <= 1'b0;
      resp_valid_q <= '0;
      if (enter_resp) begin
        state_q <= RESP;
        if (hit_timeout) locked_q <= 1'b1;
        // An owner that has let go of its request gets no pulse, and the
        // result registers keep the previous response.
        if (req[owner_q]) begin
          resp_valid_q <= grant_q;
          resp_q_q     <= resp_q_d;
          resp_r_q     <= resp_r_d;
          resp_err_q   <= resp_err_d;
        end
      end else begin
        case (state_q)
          IDLE: begin
            if (!locked_q && owner_vld_d) begin
              owner_q    <= owner_d;
              grant_q    <= N_REQ'(1) << owner_d;
              div_i_q    <= req_i[owner_d*DW +: DW];
              div_j_q    <= req_j[owner_d*DW +: DW];
              resp_err_q <= 1'b0;
              state_q    <= ISSUE;
            end
          end
          ISSUE: begin
            div_en_q <= 1'b1;
            timer_q  <= '0;
            state_q  <= WAIT;
          end
          WAIT: timer_q <= timer_q + 1'b1;
          RESP: begin
            grant_q  <= '0;
            rr_ptr_q <= (owner_q == PW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
            gap_q    <= '0;
            state_q  <= locked_q ? LOCK : GAP_S;
          end
          GAP_S: begin
            // Gives the divider time to fall back to its own idle state.
            if (gap_q == GW'(GAP - 1)) state_q <= IDLE;
            else                       gap_q   <= gap_q + 1'b1;
          end
          LOCK:    ;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign grant      = grant_q;
  assign resp_valid = resp_valid_q;
  assign resp_q     = resp_q_q;
  assign resp_r     = resp_r_q;
  assign resp_err   = resp_err_q;
  assign locked     = locked_q;
  assign div_en     = div_en_q;
  assign div_i      = div_i_q;
  assign div_j      = div_j_q;

endmodule
